// File: rtl/keypad_scanner_pkg.sv
//==============================================================================
// Module  : keypad_pkg
// Purpose : Shared types, geometry constants and helpers for the 4x4 matrix
//           keypad scanner (scan FSM states, row drive pattern, column pick).
// Ports   : none (package)
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEY_W = 4;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  // Row 0 driven low, every other row released.
  localparam logic [ROWS-1:0] ROW_IDLE = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  // Active-low one-hot row drive: ROW_IDLE rotated left by the row index.
  function automatic logic [ROWS-1:0] row_drive(input logic [ROW_W-1:0] row);
    logic [ROWS-1:0] drv;
    drv = ROW_IDLE;
    for (int i = 0; i < ROWS; i++) begin
      if (ROW_W'(i) < row) begin
        drv = {drv[ROWS-2:0], drv[ROWS-1]};
      end
    end
    return drv;
  endfunction

  // Index of the lowest-numbered low (pressed) column.
  function automatic logic [COL_W-1:0] first_low(input logic [COLS-1:0] cols);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!cols[i]) begin
        idx = COL_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_if.sv
//==============================================================================
// Module  : keypad_scanner_if
// Purpose : Key-code delivery channel between the keypad scanner and its
//           consumer (valid/ready handshake plus sticky overrun flag).
// Signals : key_code  - row*4 + col of the accepted key
//           key_valid - a key code is pending
//           key_ready - consumer accepts key_code while key_valid is high
//           overrun   - sticky, a pending key was overwritten
// Modports: master (scanner side), slave (consumer side)
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ready;
  logic             overrun;

  modport master (
    output key_code,
    output key_valid,
    output overrun,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  overrun,
    output key_ready
  );

endinterface

`default_nettype wire

// File: rtl/keypad_scanner_tick_gen.sv
//==============================================================================
// Module  : keypad_tick_gen
// Purpose : Free-running divider producing a one-cycle scan-tick enable every
//           DIV clock cycles (count 0..DIV-1, pulse on DIV-1, then wrap).
// Ports   : clk    - system clock, rising edge
//           rst_n  - asynchronous active-low reset
//           o_tick - one-cycle enable pulse
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module keypad_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_count == c_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tick = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
//==============================================================================
// Module  : keypad_scanner
// Purpose : 4x4 matrix keypad scanner. Drives one row low at a time, reads the
//           synchronized columns on each scan tick, debounces press and
//           release, and posts the key code over a valid/ready channel.
// Ports   : SYS_CLK - system clock, rising edge
//           RST     - asynchronous active-low reset
//           col_in  - keypad columns, active-low, externally pulled up
//           row_out - keypad row drive, active-low one-hot
//           kif     - key_code / key_valid / key_ready / overrun (master)
// Options : KEYPAD_REPEAT_EN - auto-repeat while a key is held
//           (adds REPEAT_DELAY / REPEAT_RATE parameters and repeat counter)
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 250,
  parameter int REPEAT_RATE  = 50
`endif
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  input  logic [COLS-1:0]   col_in,
  output logic [ROWS-1:0]   row_out,
  keypad_scanner_if.master  kif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  // The counter is checked before its increment, so DEBOUNCE_CNT-1 is the
  // value that completes DEBOUNCE_CNT consistent ticks.
  localparam logic [CNT_W-1:0] c_db_last = CNT_W'(DEBOUNCE_CNT - 1);

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] c_rep_delay_last = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] c_rep_rate_last  = REP_W'(REPEAT_RATE - 1);
`endif

  // Column synchronizer; resets to the pulled-up (no key) level.
  logic [COLS-1:0]  r_col_meta;
  logic [COLS-1:0]  r_col_sync;

  logic             w_tick;
  state_t           r_state, w_state_nxt;
  logic [ROW_W-1:0] r_row,   w_row_nxt;
  logic [COL_W-1:0] r_col,   w_col_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             w_accept;

  logic [KEY_W-1:0] r_key_code;
  logic             r_key_valid;
  logic             r_overrun;

  logic             w_pressed;
  logic             w_col_low;

`ifdef KEYPAD_REPEAT_EN
  logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic             r_rep_first, w_rep_first_nxt;
`endif

  keypad_tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk    (SYS_CLK),
    .rst_n  (RST),
    .o_tick (w_tick)
  );

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_col_meta <= '1;
      r_col_sync <= '1;
    end else begin
      r_col_meta <= col_in;
      r_col_sync <= r_col_meta;
    end
  end

  assign w_pressed = (r_col_sync != '1);
  assign w_col_low = ~r_col_sync[r_col];

  // State register
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_state <= SCAN;
      r_row   <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else begin
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_rep_first <= w_rep_first_nxt;
    end
  end
`endif

  // Next-state logic; everything advances only on a scan tick.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_cnt_nxt   = r_rep_cnt;
    w_rep_first_nxt = r_rep_first;
`endif

    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_pressed) begin
            // Row stays put so the captured key keeps being driven.
            w_col_nxt   = first_low(r_col_sync);
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = DEBOUNCE;
          end else begin
            w_row_nxt = r_row + ROW_W'(1);
          end
        end

        DEBOUNCE: begin
          if (w_col_low) begin
            if (r_cnt == c_db_last) begin
              w_accept    = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = HELD;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_cnt_nxt   = '0;
            w_row_nxt   = r_row + ROW_W'(1);
            w_state_nxt = SCAN;
          end
        end

        HELD: begin
          if (!w_pressed) begin
            if (r_cnt == c_db_last) begin
              w_cnt_nxt   = '0;
              w_row_nxt   = '0;
              w_state_nxt = SCAN;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_cnt_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
            if (w_col_low) begin
              if (!r_rep_first && (r_rep_cnt == c_rep_delay_last)) begin
                w_accept        = 1'b1;
                w_rep_cnt_nxt   = '0;
                w_rep_first_nxt = 1'b1;
              end else if (r_rep_first && (r_rep_cnt == c_rep_rate_last)) begin
                w_accept      = 1'b1;
                w_rep_cnt_nxt = '0;
              end else begin
                w_rep_cnt_nxt = r_rep_cnt + REP_W'(1);
              end
            end else begin
              w_rep_cnt_nxt   = '0;
              w_rep_first_nxt = 1'b0;
            end
`endif
          end
`ifdef KEYPAD_REPEAT_EN
          if (!w_pressed) begin
            w_rep_cnt_nxt   = '0;
            w_rep_first_nxt = 1'b0;
          end
`endif
        end

        default: begin
          w_state_nxt = SCAN;
        end
      endcase
    end

`ifdef KEYPAD_REPEAT_EN
    if (w_state_nxt != HELD) begin
      w_rep_cnt_nxt   = '0;
      w_rep_first_nxt = 1'b0;
    end
`endif
  end

  // Key delivery. A coincident accept wins over the handshake clear, and a
  // consumer taking the old code in that cycle means nothing was lost.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_accept) begin
      r_key_code  <= {r_row, r_col};
      r_key_valid <= 1'b1;
      if (r_key_valid && !kif.key_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_key_valid && kif.key_ready) begin
      r_key_valid <= 1'b0;
    end
  end

  assign row_out       = row_drive(r_row);
  assign kif.key_code  = r_key_code;
  assign kif.key_valid = r_key_valid;
  assign kif.overrun   = r_overrun;

endmodule

`default_nettype wire
